// File: rtl/alu_pkg.sv
// Shared constants for the serial ALU: control codes,
// operation field codes and FSM states.
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN,
    DONE
  } state_t;

endpackage

// File: rtl/alu_nibble.sv
// Combinational 4-bit ALU slice: invert, logic ops
// and a carry-chained adder.
module alu_nibble
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic [1:0] operation,
  input  logic       cin,
  output logic [3:0] res,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] aa;
  logic [3:0] bb;
  logic [4:0] full;

  assign aa   = a ^ {4{a_invert}};
  assign bb   = b ^ {4{b_invert}};
  assign full = {1'b0, aa} + {1'b0, bb}
              + {4'b0, cin};
  assign sum  = full[3:0];
  assign cout = full[4];

  // less is resolved for the whole word later
  always_comb begin
    res = 4'b0;
    unique case (operation)
      OP_AND:  res = aa & bb;
      OP_OR:   res = aa | bb;
      OP_SUM:  res = sum;
      OP_LESS: res = 4'b0;
      default: res = 4'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial32.sv
// Nibble-serial 32-bit ALU with valid/ready request
// and response ports.
module alu_serial32
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       ctrl_q;
  logic             a_msb;
  logic             b_msb;
  logic             zero_q;
  logic             cout_q;
  logic             ovf_q;

  logic [3:0] nib_res;
  logic [3:0] nib_sum;
  logic       nib_cout;
  logic [3:0] nib_out;
  logic       ovf_raw;
  logic       set;

  alu_nibble u_nib (
    .a         (a_q[3:0]),
    .b         (b_q[3:0]),
    .a_invert  (ctrl_q[3]),
    .b_invert  (ctrl_q[2]),
    .operation (ctrl_q[1:0]),
    .cin       (carry),
    .res       (nib_res),
    .sum       (nib_sum),
    .cout      (nib_cout)
  );

  // arithmetic ops keep the raw sum so the sign is in res_q
  assign nib_out = ctrl_q[1] ? nib_sum : nib_res;
  assign ovf_raw = (a_msb ~^ b_msb)
                 & (res_q[WIDTH-1] ^ a_msb);
  assign set     = res_q[WIDTH-1] ^ ovf_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      ctrl_q <= 4'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      zero_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= src1;
            b_q    <= src2;
            ctrl_q <= alu_ctrl;
            cnt    <= '0;
            carry  <= alu_ctrl[2];
            state  <= RUN;
          end
        end
        RUN: begin
          res_q <= {nib_out, res_q[WIDTH-1:4]};
          a_q   <= {4'b0, a_q[WIDTH-1:4]};
          b_q   <= {4'b0, b_q[WIDTH-1:4]};
          carry <= nib_cout;
          a_msb <= a_q[3] ^ ctrl_q[3];
          b_msb <= b_q[3] ^ ctrl_q[2];
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
          if (ctrl_q[1:0] == OP_LESS) begin
            res_q  <= {{(WIDTH-1){1'b0}}, set};
            zero_q <= ~set;
          end else begin
            zero_q <= (res_q == '0);
          end
          cout_q <= ctrl_q[1] & carry;
          ovf_q  <= (ctrl_q[1:0] == OP_SUM)
                    & ovf_raw;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign zero      = zero_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_serial32.sv
// Directed bench for alu_serial32: arithmetic, logic,
// handshake stalls and mid-operation reset.
module tb_alu_serial32;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [3:0]  alu_ctrl = 4'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  alu_serial32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .alu_ctrl  (alu_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [3:0]  c);
    int n;
    n = 0;
    @(negedge clk);
    src1 = a;
    src2 = b;
    alu_ctrl = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // latency = edges from accept to first edge seeing out_valid
  task automatic wait_resp(input string tag);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    chk({tag, "_lat"}, lat, 10);
  endtask

  task automatic check_resp(input string tag,
                            input logic [31:0] r,
                            input logic z,
                            input logic c,
                            input logic o);
    chk({tag, "_res"}, result, r);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, z});
    chk({tag, "_cout"}, {31'b0, cout}, {31'b0, c});
    chk({tag, "_ovf"}, {31'b0, overflow},
        {31'b0, o});
    chk({tag, "_busy"}, {31'b0, in_ready}, 0);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'b0, in_ready}, 1);
    chk({tag, "_ov"}, {31'b0, out_valid}, 0);
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [3:0] c,
                        input logic [31:0] r,
                        input logic z,
                        input logic co,
                        input logic o);
    issue(a, b, c);
    wait_resp(tag);
    check_resp(tag, r, z, co, o);
    consume(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ov", {31'b0, out_valid}, 0);
    chk("rst_res", result, 0);
    chk("rst_flags", {29'b0, zero, cout, overflow}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", {31'b0, in_ready}, 1);

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h1, CTRL_ADD,
           32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op("sub_eq", 32'h1234_5678, 32'h1234_5678,
           CTRL_SUB, 32'h0, 1'b1, 1'b1, 1'b0);
    run_op("slt_neg", 32'hFFFF_FFFF, 32'h1, CTRL_SLT,
           32'h1, 1'b0, 1'b1, 1'b0);
    run_op("slt_ovf", 32'h7FFF_FFFF, 32'h8000_0000,
           CTRL_SLT, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("and", 32'hF0F0_A5A5, 32'h0FF0_5A5A,
           CTRL_AND, 32'h00F0_0000, 1'b0, 1'b0, 1'b0);
    run_op("or", 32'hF0F0_A5A5, 32'h0FF0_5A5A,
           CTRL_OR, 32'hFFF0_FFFF, 1'b0, 1'b0, 1'b0);
    run_op("nor", 32'hF0F0_A5A5, 32'h0FF0_5A5A,
           CTRL_NOR, 32'h000F_0000, 1'b0, 1'b0, 1'b0);

    // stalled response with a request waiting behind it
    issue(32'h10, 32'h20, CTRL_ADD);
    src1 = 32'h5;
    src2 = 32'h3;
    alu_ctrl = CTRL_SUB;
    in_valid = 1'b1;
    wait_resp("hs");
    for (int i = 0; i < 5; i++) begin
      check_resp("hs_hold", 32'h30, 1'b0, 1'b0, 1'b0);
      chk("hs_ov", {31'b0, out_valid}, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("hs_rdy_after", {31'b0, in_ready}, 1);
    chk("hs_ov_after", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("hs_taken", {31'b0, in_ready}, 0);
    begin
      int lat;
      lat = 1;
      while (!out_valid && lat < 50) begin
        @(negedge clk);
        lat++;
      end
      chk("hs2_lat", lat, 10);
    end
    check_resp("hs2", 32'h2, 1'b0, 1'b1, 1'b0);
    consume("hs2");

    // reset during nibble processing
    issue(32'h1111_1111, 32'h2222_2222, CTRL_ADD);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ov", {31'b0, out_valid}, 0);
    chk("mrst_rdy", {31'b0, in_ready}, 1);
    chk("mrst_res", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'h5, 32'h3, CTRL_ADD,
           32'h8, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
